// File: rtl/div_unit_pkg.sv
// Shared definitions for the multicycle signed divider: FSM encoding, iteration
// count and the HI/LO write-path mux select codes.
package div_unit_pkg;

    localparam int DIV_ITER = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } div_state_e;

    // Select codes for the 3-input HI/LO data mux; data_1 = lo_out, data_2 = hi_out.
    typedef enum logic [1:0] {
        HILO_SEL_D0 = 2'd0,
        HILO_SEL_LO = 2'd1,
        HILO_SEL_HI = 2'd2
    } hilo_sel_e;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// trial-subtract the divisor magnitude.
module div_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH:0]   rem_i,
    input  logic                  bit_i,
    input  logic [DATA_WIDTH-1:0] dvsr_i,
    output logic [DATA_WIDTH:0]   rem_o,
    output logic                  qbit_o
);

    // One extra bit of headroom so the sign of the trial result is explicit.
    logic [DATA_WIDTH+1:0] shifted;
    logic [DATA_WIDTH+1:0] trial;

    always_comb begin
        shifted = {rem_i, bit_i};
        trial   = shifted - {2'b00, dvsr_i};
        qbit_o  = ~trial[DATA_WIDTH+1];
        rem_o   = qbit_o ? trial[DATA_WIDTH:0] : shifted[DATA_WIDTH:0];
    end

endmodule

// File: rtl/div_unit.sv
// Multicycle signed divider (DIV): LO = quotient truncated toward zero,
// HI = remainder with the sign of the dividend.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_WIDTH = DIV_ITER,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  div_start,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] lo_out,
    output logic [DATA_WIDTH-1:0] hi_out,
    output logic                  div_done,
    output logic                  div_zero,
    output logic                  div_busy
);

    div_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH:0]   rem_q, rem_d;
    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    logic [DATA_WIDTH-1:0] dvsr_q, dvsr_d;
    logic                  sa_q, sa_d;
    logic                  sb_q, sb_d;
    logic [DATA_WIDTH-1:0] lo_q, lo_d;
    logic [DATA_WIDTH-1:0] hi_q, hi_d;
    logic                  zero_q, zero_d;

    logic [DATA_WIDTH:0]   step_rem;
    logic                  step_qbit;

    // quo_q shifts dividend magnitude out of the MSB while quotient bits enter the LSB.
    div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .rem_i  (rem_q),
        .bit_i  (quo_q[DATA_WIDTH-1]),
        .dvsr_i (dvsr_q),
        .rem_o  (step_rem),
        .qbit_o (step_qbit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvsr_q  <= dvsr_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvsr_d  = dvsr_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        zero_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (div_start) begin
                    if (divisor == '0) begin
                        zero_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        // Magnitudes are unsigned, so -2^(W-1) maps onto its own bit pattern.
                        quo_d   = dividend[DATA_WIDTH-1] ? -dividend : dividend;
                        dvsr_d  = divisor[DATA_WIDTH-1]  ? -divisor  : divisor;
                        sa_d    = dividend[DATA_WIDTH-1];
                        sb_d    = divisor[DATA_WIDTH-1];
                        rem_d   = '0;
                        cnt_d   = '0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = {quo_q[DATA_WIDTH-2:0], step_qbit};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_WIDTH'(DATA_WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                lo_d    = (sa_q ^ sb_q) ? -quo_q : quo_q;
                hi_d    = sa_q ? -rem_q[DATA_WIDTH-1:0] : rem_q[DATA_WIDTH-1:0];
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign lo_out   = lo_q;
    assign hi_out   = hi_q;
    assign div_done = (state_q == DONE);
    assign div_zero = zero_q;
    assign div_busy = (state_q == CALC) || (state_q == FIX);

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
Multicycle signed 32-bit divider for the datapath; implements DIV semantics (LO = quotient, HI = remainder).
- Started by the control unit with a one-cycle pulse.
- Registered HI/LO results feed the 3-input 32-bit data-select mux that drives the HI/LO write path. `data_1` of that mux is `lo_out`; `data_2` is `hi_out`.
- Raises `div_zero` to the control unit for exception handling.

Parameters:
- DATA_WIDTH, 32, operand and result width.
- CNT_WIDTH, 6, iteration counter width (must hold DATA_WIDTH).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- div_start  input  1  start request, sampled only in IDLE
- dividend  input  DATA_WIDTH  signed dividend (rs), sampled with div_start
- divisor  input  DATA_WIDTH  signed divisor (rt), sampled with div_start
- lo_out  output  DATA_WIDTH  registered quotient
- hi_out  output  DATA_WIDTH  registered remainder
- div_done  output  1  one-cycle completion pulse
- div_zero  output  1  one-cycle divide-by-zero pulse, coincident with div_done
- div_busy  output  1  high while in CALC or FIX

Behaviour:
Reset
- While reset=1: all outputs 0, state IDLE, counter 0, internal registers 0.
- Reset asserted mid-operation aborts the division immediately. No done pulse is produced and hi_out/lo_out return to 0.

State machine, states IDLE, CALC, FIX, DONE:
- IDLE: if div_start=1 at edge k:
  - divisor=0 → DONE with div_zero=1. hi_out/lo_out are not updated.
  - otherwise → CALC. Load |dividend| and |divisor|, latch both sign bits, clear the partial remainder, set counter=0.
- CALC: restoring division, one quotient bit per edge, MSB first.
  - Partial remainder is DATA_WIDTH+1 bits: shift left with the next dividend bit, trial-subtract |divisor|.
  - If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set the bit to 0.
  - After 32 iterations (edges k+1..k+32) → FIX.
- FIX (edge k+33):
  - lo_out = quotient, negated (two's complement) if the operand signs differ.
  - hi_out = remainder, negated if the dividend was negative.
  - Next state DONE.
- DONE: div_done=1 (and div_zero when applicable) for exactly one cycle; next edge → IDLE.

Timing
- Normal latency: div_done is visible in the cycle after edge k+33, i.e. 34 cycles after div_start was sampled.
- Divide-by-zero latency: div_done is visible in the cycle after edge k.

Boundary cases
- div_start while not IDLE is ignored; operand changes during CALC have no effect.
- div_start high in the DONE cycle is ignored. A new start is accepted only in IDLE, starting the cycle after DONE.
- Quotient truncates toward zero. Remainder takes the sign of the dividend, or is 0.
- Overflow −2^31 / −1: lo_out=0x80000000, hi_out=0; no flag.
- |dividend| of −2^31 is handled as the unsigned magnitude 0x80000000 (unsigned internal arithmetic).
- hi_out/lo_out hold their last value between operations and across divide-by-zero.
- div_busy=1 in CALC and FIX, 0 in IDLE and DONE.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE=2'b00, CALC=2'b01, FIX=2'b10, DONE=2'b11.
  - DIV_ITER=32.
  - The HI/LO mux select codes, used by the control unit alongside div_done.
- Sub-module div_step: purely combinational single iteration. Inputs are partial remainder, next dividend bit and divisor magnitude; outputs are the new remainder and the quotient bit. The div_unit FSM instantiates it once.

Test Plan:
- reset, then dividend=7, divisor=2, start pulse → div_done after 34 cycles; lo_out=0x00000003, hi_out=0x00000001, div_zero=0.
- dividend=−7 (0xFFFFFFF9), divisor=2 → lo_out=0xFFFFFFFD (−3), hi_out=0xFFFFFFFF (−1). Also 7/−2 → lo_out=0xFFFFFFFD, hi_out=0x00000001.
- divisor=0, dividend=5, with hi_out/lo_out previously 1/3 → div_done and div_zero high together in the cycle after the start edge; hi_out=1, lo_out=3 unchanged.
- dividend=0x80000000, divisor=0xFFFFFFFF → lo_out=0x80000000, hi_out=0, div_zero=0.
- Start 100/7, assert reset at cycle 10 → all outputs 0 immediately, no div_done. Restart 100/7 → lo_out=14, hi_out=2.
- Start 100/7, pulse div_start with 9/3 at cycle 5 and again in the DONE cycle → only one div_done; results 14/2; div_busy drops when DONE is entered.
